// File: rtl/rect_sub_column_seq.sv
// RECTANGLE round front-end: AddRoundKey then SubColumn, COLS_PER_CYCLE columns
// per clock. The finished state is held on sub_state for the ShiftRow stage.
module rect_sub_column_seq #(
  parameter int unsigned COLS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] state_in,
  input  logic [63:0] round_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sub_state,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [4:0] ColStep = 5'(COLS_PER_CYCLE);

  // Only divisors of 16 give a whole number of BUSY cycles.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4 ||
          COLS_PER_CYCLE == 8 || COLS_PER_CYCLE == 16)) begin : g_bad_cols
      $fatal(1, "rect_sub_column_seq: COLS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [63:0] res_q, res_d;
  logic [63:0] sub_work;
  logic [3:0]  col_arr [16];
  logic [3:0]  col_idx;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Substitute the window of columns starting at the counter; others pass through.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      col_arr[j] = {work_q[48+j], work_q[32+j], work_q[16+j], work_q[j]};
    end
    col_idx = '0;
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      // The counter is a multiple of the step, so the window never passes column 15.
      col_idx          = cnt_q[3:0] + 4'(k);
      col_arr[col_idx] = sbox(col_arr[col_idx]);
    end
    sub_work = '0;
    for (int j = 0; j < 16; j++) begin
      sub_work[j]    = col_arr[j][0];
      sub_work[16+j] = col_arr[j][1];
      sub_work[32+j] = col_arr[j][2];
      sub_work[48+j] = col_arr[j][3];
    end
  end

  // Next-state logic for the IDLE -> BUSY -> DONE handshake sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Key is mixed in once here; round_key is not looked at again.
          work_d  = state_in ^ round_key;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        work_d = sub_work;
        cnt_d  = cnt_q + ColStep;
        if (cnt_d == 5'd16) begin
          // Result register is only loaded with a fully substituted state.
          res_d   = sub_work;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  // Outputs decode directly from state so they never depend on inputs.
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    sub_state = res_q;
  end

endmodule

// File: tb/tb_rect_sub_column_seq.sv
// Scoreboard bench for rect_sub_column_seq: directed vectors on the default
// configuration plus a column-count sweep against a reference S-box model.
module tb_rect_sub_column_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sw_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] state_in;
  logic [63:0] round_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sub_state;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp_q [$];

  localparam logic [63:0] ExpZero   = 64'h0000_FFFF_FFFF_0000;
  localparam logic [63:0] ExpOnes   = 64'h0000_0000_FFFF_0000;
  localparam logic [63:0] ExpSingle = 64'h0000_FFFF_FFFE_0001;

  always #5 clk = ~clk;

  rect_sub_column_seq #(.COLS_PER_CYCLE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sub_state (sub_state),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  function automatic logic [63:0] sub_col_ref(input logic [63:0] s);
    logic [3:0]  tbl [16];
    logic [3:0]  y;
    logic [63:0] r;
    tbl = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
            4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
    r = '0;
    for (int j = 0; j < 16; j++) begin
      y = tbl[{s[48+j], s[32+j], s[16+j], s[j]}];
      r[j]    = y[0];
      r[16+j] = y[1];
      r[32+j] = y[2];
      r[48+j] = y[3];
    end
    return r;
  endfunction

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("main unexpected output");
      else check("main result", sub_state, exp_q.pop_front());
    end
  end

  task automatic send(input logic [63:0] s, input logic [63:0] k, input logic [63:0] e);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("main send wait in_ready");
    in_valid  = 1'b1;
    state_in  = s;
    round_key = k;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid  = 1'b0;
    round_key = ~k;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail_now("main drain");
  endtask

  // Sweep: one instance per alternative column count, each with its own driver/monitor.
  localparam int unsigned SwP [4] = '{1, 2, 8, 16};

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int unsigned P = SwP[g];
    logic        iv = 1'b0;
    logic        ir;
    logic        ov;
    logic        bz;
    logic [63:0] si = '0;
    logic [63:0] rk = '0;
    logic [63:0] ss;
    logic [63:0] q [$];
    logic        done = 1'b0;

    rect_sub_column_seq #(.COLS_PER_CYCLE(P)) u_sw (
      .clk       (clk),
      .rst_n     (sw_rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .state_in  (si),
      .round_key (rk),
      .out_valid (ov),
      .out_ready (1'b1),
      .sub_state (ss),
      .busy      (bz)
    );

    always @(negedge clk) begin
      #1;
      if (sw_rst_n && ov) begin
        if (q.size() == 0) fail_now($sformatf("sweep%0d unexpected output", P));
        else check($sformatf("sweep%0d result", P), ss, q.pop_front());
      end
    end

    initial begin
      logic [63:0] s;
      logic [63:0] k;
      int          t;
      int          blen;
      wait (sw_rst_n === 1'b1);
      @(negedge clk);
      for (int i = 0; i <= 1000; i++) begin
        if (i == 0) begin
          s = 64'h0123_4567_89AB_CDEF;
          k = '0;
        end else begin
          s = {$urandom(), $urandom()};
          k = {$urandom(), $urandom()};
        end
        t = 0;
        while (!ir && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (!ir) fail_now($sformatf("sweep%0d wait in_ready", P));
        iv = 1'b1;
        si = s;
        rk = k;
        q.push_back(sub_col_ref(s ^ k));
        @(negedge clk);
        iv   = 1'b0;
        rk   = ~k;
        blen = 0;
        while (bz && blen < 40) begin
          blen++;
          @(negedge clk);
        end
        check($sformatf("sweep%0d busy length", P), 64'(blen), 64'(16 / P));
      end
      t = 0;
      while (q.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0) fail_now($sformatf("sweep%0d drain", P));
      done = 1'b1;
    end
  end

  // Main directed sequence on the default configuration.
  initial begin
    int lat;
    int t;
    rst_n     = 1'b0;
    sw_rst_n  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state_in  = '0;
    round_key = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset sub_state", sub_state, 64'd0);
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    @(negedge clk);

    // Zero vector with latency measured from the accepting cycle.
    in_valid  = 1'b1;
    state_in  = '0;
    round_key = '0;
    exp_q.push_back(ExpZero);
    @(negedge clk);
    in_valid  = 1'b0;
    round_key = 64'hA5A5_A5A5_A5A5_A5A5;
    lat = 1;
    check("busy after accept", 64'(busy), 64'd1);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd5);
    wait_drain();

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, ExpOnes);
    send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, ExpZero);
    send(64'h0000_0000_0000_0001, 64'h0, ExpSingle);
    wait_drain();

    // Backpressure: result must hold and a new request must be refused.
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0001, 64'h0, ExpSingle);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail_now("bp wait out_valid");
    in_valid  = 1'b1;
    state_in  = 64'hDEAD_BEEF_CAFE_F00D;
    round_key = 64'h0;
    for (int c = 0; c < 10; c++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
      check("bp sub_state", sub_state, ExpSingle);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    check("bp not accepted", 64'(busy), 64'd0);
    wait_drain();

    // Reset during the second BUSY cycle.
    in_valid = 1'b1;
    state_in = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst sub_state", sub_state, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(64'h0, 64'h0, ExpZero);
    wait_drain();

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)) begin
      fail_now("sweep completion");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
